// File: rtl/excp_commit.sv
// rtl/excp_commit.sv - commit-stage exception/interrupt/ERTN sequencer with fetch redirect
module excp_commit (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [31:0] wb_pc,
    input  logic        wb_excp_valid,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_waddr,
    input  logic [31:0] wb_csr_wdata,
    input  logic        has_int,
    input  logic [31:0] eentry,
    input  logic [31:0] era,
    output logic        csr_wr_en,
    output logic [13:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        excp_flush,
    output logic [31:0] era_out,
    output logic [5:0]  ecode_out,
    output logic [8:0]  esubcode_out,
    output logic        ertn_flush,
    output logic        flush_pipe,
    output logic        redirect_valid,
    input  logic        redirect_ready,
    output logic [31:0] redirect_pc,
    output logic [31:0] commit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Remembers whether the pending redirect targets ERA (ERTN) or EENTRY (trap).
    logic   redirect_to_era;

    logic   accept;
    logic   take_int;
    logic   take_excp;
    logic   take_ertn;
    logic   take_norm;
    logic   take_trap;
    logic   redirect_fire;

    // Event classification: interrupt outranks exception, which outranks ERTN.
    always_comb begin
        accept        = wb_valid & wb_ready;
        take_int      = accept & has_int;
        take_excp     = accept & ~has_int & wb_excp_valid;
        take_ertn     = accept & ~has_int & ~wb_excp_valid & wb_ertn;
        take_norm     = accept & ~has_int & ~wb_excp_valid & ~wb_ertn;
        take_trap     = take_int | take_excp;
        redirect_fire = redirect_valid & redirect_ready;
    end

    // State register; reset drops straight back to IDLE from anywhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_d        = state_q;
        wb_ready       = 1'b0;
        flush_pipe     = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                wb_ready = 1'b1;
                if (take_trap || take_ertn) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_pipe = 1'b1;
                state_d    = S_REDIRECT;
            end
            S_REDIRECT: begin
                flush_pipe     = 1'b1;
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single-cycle strobes toward the CSR file, only set in the cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            excp_flush <= 1'b0;
            ertn_flush <= 1'b0;
            csr_wr_en  <= 1'b0;
        end else begin
            excp_flush <= take_trap;
            ertn_flush <= take_ertn;
            csr_wr_en  <= take_norm & wb_csr_we;
        end
    end

    // CSR write address/data follow the last normally retired instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csr_waddr <= 14'd0;
            csr_wdata <= 32'd0;
        end else if (take_norm) begin
            csr_waddr <= wb_csr_waddr;
            csr_wdata <= wb_csr_wdata;
        end
    end

    // Trap record for the CSR file; interrupts report ecode/esubcode of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            era_out      <= 32'd0;
            ecode_out    <= 6'd0;
            esubcode_out <= 9'd0;
        end else if (take_int) begin
            era_out      <= wb_pc;
            ecode_out    <= 6'd0;
            esubcode_out <= 9'd0;
        end else if (take_excp) begin
            era_out      <= wb_pc;
            ecode_out    <= wb_ecode;
            esubcode_out <= wb_esubcode;
        end
    end

    // Retired-instruction counter; traps do not retire, ERTN does. Wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_cnt <= 32'd0;
        end else if (take_norm || take_ertn) begin
            commit_cnt <= commit_cnt + 32'd1;
        end
    end

    // Redirect kind is captured at acceptance, the target when leaving FLUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_to_era <= 1'b0;
            redirect_pc     <= 32'd0;
        end else begin
            if (take_trap || take_ertn) begin
                redirect_to_era <= take_ertn;
            end
            if (state_q == S_FLUSH) begin
                redirect_pc <= redirect_to_era ? era : eentry;
            end else if (redirect_fire) begin
                redirect_pc <= redirect_pc;
            end
        end
    end

endmodule

// File: tb/tb_excp_commit.sv
// tb/tb_excp_commit.sv - directed self-checking bench for excp_commit
module tb_excp_commit;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc;
    logic        wb_excp_valid;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        wb_ertn;
    logic        wb_csr_we;
    logic [13:0] wb_csr_waddr;
    logic [31:0] wb_csr_wdata;
    logic        has_int;
    logic [31:0] eentry;
    logic [31:0] era;
    logic        csr_wr_en;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        excp_flush;
    logic [31:0] era_out;
    logic [5:0]  ecode_out;
    logic [8:0]  esubcode_out;
    logic        ertn_flush;
    logic        flush_pipe;
    logic        redirect_valid;
    logic        redirect_ready;
    logic [31:0] redirect_pc;
    logic [31:0] commit_cnt;

    int checks = 0;
    int errors = 0;

    excp_commit dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_pc          (wb_pc),
        .wb_excp_valid  (wb_excp_valid),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_ertn        (wb_ertn),
        .wb_csr_we      (wb_csr_we),
        .wb_csr_waddr   (wb_csr_waddr),
        .wb_csr_wdata   (wb_csr_wdata),
        .has_int        (has_int),
        .eentry         (eentry),
        .era            (era),
        .csr_wr_en      (csr_wr_en),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .excp_flush     (excp_flush),
        .era_out        (era_out),
        .ecode_out      (ecode_out),
        .esubcode_out   (esubcode_out),
        .ertn_flush     (ertn_flush),
        .flush_pipe     (flush_pipe),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .commit_cnt     (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid      = 1'b0;
        wb_pc         = 32'd0;
        wb_excp_valid = 1'b0;
        wb_ecode      = 6'd0;
        wb_esubcode   = 9'd0;
        wb_ertn       = 1'b0;
        wb_csr_we     = 1'b0;
        wb_csr_waddr  = 14'd0;
        wb_csr_wdata  = 32'd0;
        has_int       = 1'b0;
    endtask

    initial begin
        idle_inputs();
        eentry         = 32'h1C008000;
        era            = 32'h0;
        redirect_ready = 1'b0;
        reset          = 1'b0;
        #22;
        // Reset state
        check("rst_wb_ready", {31'd0, wb_ready}, 32'd1);
        check("rst_flush_pipe", {31'd0, flush_pipe}, 32'd0);
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_commit_cnt", commit_cnt, 32'd0);
        check("rst_excp_flush", {31'd0, excp_flush}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        reset = 1'b1;
        tick();

        // Normal CSR write
        wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_waddr = 14'h30; wb_csr_wdata = 32'hDEADBEEF;
        check("n_wb_ready", {31'd0, wb_ready}, 32'd1);
        tick();
        idle_inputs();
        check("n_csr_wr_en_t1", {31'd0, csr_wr_en}, 32'd1);
        check("n_csr_waddr", {18'd0, csr_waddr}, 32'h30);
        check("n_csr_wdata", csr_wdata, 32'hDEADBEEF);
        check("n_cnt_t1", commit_cnt, 32'd1);
        check("n_flush_pipe", {31'd0, flush_pipe}, 32'd0);
        tick();
        check("n_csr_wr_en_t2", {31'd0, csr_wr_en}, 32'd0);
        check("n_cnt_t2", commit_cnt, 32'd1);

        // Exception with immediate redirect acceptance
        wb_valid = 1'b1; wb_excp_valid = 1'b1; wb_pc = 32'h1C000100; wb_ecode = 6'h0B;
        wb_esubcode = 9'h005; wb_csr_we = 1'b1; wb_csr_waddr = 14'h7; wb_csr_wdata = 32'h1111;
        eentry = 32'h1C008000; redirect_ready = 1'b1;
        tick();
        idle_inputs();
        check("e_excp_flush_t1", {31'd0, excp_flush}, 32'd1);
        check("e_era_out", era_out, 32'h1C000100);
        check("e_ecode_out", {26'd0, ecode_out}, 32'h0B);
        check("e_esubcode_out", {23'd0, esubcode_out}, 32'h005);
        check("e_csr_suppressed", {31'd0, csr_wr_en}, 32'd0);
        check("e_flush_pipe_t1", {31'd0, flush_pipe}, 32'd1);
        check("e_wb_ready_t1", {31'd0, wb_ready}, 32'd0);
        check("e_redirect_valid_t1", {31'd0, redirect_valid}, 32'd0);
        tick();
        check("e_excp_flush_t2", {31'd0, excp_flush}, 32'd0);
        check("e_redirect_valid_t2", {31'd0, redirect_valid}, 32'd1);
        check("e_redirect_pc", redirect_pc, 32'h1C008000);
        tick();
        check("e_idle_wb_ready", {31'd0, wb_ready}, 32'd1);
        check("e_idle_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("e_idle_flush_pipe", {31'd0, flush_pipe}, 32'd0);
        check("e_cnt", commit_cnt, 32'd1);

        // Interrupt beats exception and CSR write
        wb_valid = 1'b1; has_int = 1'b1; wb_excp_valid = 1'b1; wb_ecode = 6'h15;
        wb_esubcode = 9'h1AA; wb_csr_we = 1'b1; wb_pc = 32'h1C000300; eentry = 32'h1C009000;
        tick();
        idle_inputs();
        check("i_excp_flush", {31'd0, excp_flush}, 32'd1);
        check("i_ecode_out", {26'd0, ecode_out}, 32'd0);
        check("i_esubcode_out", {23'd0, esubcode_out}, 32'd0);
        check("i_era_out", era_out, 32'h1C000300);
        check("i_csr_wr_en", {31'd0, csr_wr_en}, 32'd0);
        tick();
        check("i_redirect_pc", redirect_pc, 32'h1C009000);
        check("i_csr_wr_en_t2", {31'd0, csr_wr_en}, 32'd0);
        tick();
        check("i_cnt", commit_cnt, 32'd1);

        // ERTN with three cycles of redirect backpressure
        wb_valid = 1'b1; wb_ertn = 1'b1; era = 32'h1C000200; redirect_ready = 1'b0;
        tick();
        idle_inputs();
        check("r_ertn_flush_t1", {31'd0, ertn_flush}, 32'd1);
        check("r_excp_flush_t1", {31'd0, excp_flush}, 32'd0);
        check("r_cnt", commit_cnt, 32'd2);
        check("r_era_out_held", era_out, 32'h1C000300);
        check("r_wb_ready_t1", {31'd0, wb_ready}, 32'd0);
        tick();
        era = 32'h12345678;
        wb_valid = 1'b1; wb_csr_we = 1'b1; wb_excp_valid = 1'b1; has_int = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("r_redirect_valid", {31'd0, redirect_valid}, 32'd1);
            check("r_redirect_pc", redirect_pc, 32'h1C000200);
            check("r_wb_ready", {31'd0, wb_ready}, 32'd0);
            check("r_flush_pipe", {31'd0, flush_pipe}, 32'd1);
            check("r_ertn_flush_low", {31'd0, ertn_flush}, 32'd0);
            check("r_ignored_excp", {31'd0, excp_flush}, 32'd0);
            check("r_ignored_cnt", commit_cnt, 32'd2);
            if (i == 3) begin
                idle_inputs();
                redirect_ready = 1'b1;
            end
            tick();
        end
        check("r_idle_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("r_idle_wb_ready", {31'd0, wb_ready}, 32'd1);
        check("r_ignored_csr", {31'd0, csr_wr_en}, 32'd0);

        // Reset asserted while in REDIRECT
        redirect_ready = 1'b0; eentry = 32'h1C00A000;
        wb_valid = 1'b1; wb_excp_valid = 1'b1; wb_pc = 32'h1C000400; wb_ecode = 6'h3;
        tick();
        idle_inputs();
        tick();
        check("x_pre_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("x_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("x_flush_pipe", {31'd0, flush_pipe}, 32'd0);
        check("x_wb_ready", {31'd0, wb_ready}, 32'd1);
        check("x_cnt", commit_cnt, 32'd0);
        check("x_era_out", era_out, 32'd0);
        check("x_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // First instruction after reset accepted on the first edge
        wb_valid = 1'b1; wb_csr_we = 1'b1; wb_csr_waddr = 14'h3FFF; wb_csr_wdata = 32'hA5A5A5A5;
        tick();
        idle_inputs();
        check("p_csr_wr_en", {31'd0, csr_wr_en}, 32'd1);
        check("p_csr_waddr", {18'd0, csr_waddr}, 32'h3FFF);
        check("p_cnt", commit_cnt, 32'd1);

        // Counter wrap
        @(negedge clk);
        force dut.commit_cnt = 32'hFFFFFFFF;
        #1;
        release dut.commit_cnt;
        check("w_preset", commit_cnt, 32'hFFFFFFFF);
        wb_valid = 1'b1;
        tick();
        idle_inputs();
        check("w_wrap", commit_cnt, 32'd0);
        check("w_no_csr", {31'd0, csr_wr_en}, 32'd0);
        tick();
        check("w_hold", commit_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
